// File: rtl/md_unit_pkg.sv
// rtl/md_unit_pkg.sv - shared op codes, latencies and result helper for md_unit
package md_unit_pkg;

   typedef enum logic [2:0] {
      OP_NONE  = 3'd0,
      OP_MULT  = 3'd1,
      OP_MULTU = 3'd2,
      OP_DIV   = 3'd3,
      OP_DIVU  = 3'd4,
      OP_MTHI  = 3'd5,
      OP_MTLO  = 3'd6
   } md_op_e;

   localparam logic SEL_LO = 1'b0;
   localparam logic SEL_HI = 1'b1;

   localparam int DEF_MULT_LATENCY = 5;
   localparam int DEF_DIV_LATENCY  = 10;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
   } md_result_t;

   // Signed divide runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000 rem 0.
   function automatic md_result_t md_compute(md_op_e op, logic [31:0] a, logic [31:0] b);
      md_result_t  res;
      logic [63:0] prod;
      logic [31:0] mag_a;
      logic [31:0] mag_b;
      logic [31:0] q;
      logic [31:0] r;
      res   = '0;
      prod  = '0;
      mag_a = '0;
      mag_b = '0;
      q     = '0;
      r     = '0;
      case (op)
         OP_MULT: begin
            prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            res  = {prod[63:32], prod[31:0]};
         end
         OP_MULTU: begin
            prod = {32'd0, a} * {32'd0, b};
            res  = {prod[63:32], prod[31:0]};
         end
         OP_DIV: begin
            if (b == '0) begin
               res = {a, 32'hFFFF_FFFF};
            end else begin
               mag_a  = a[31] ? -a : a;
               mag_b  = b[31] ? -b : b;
               q      = mag_a / mag_b;
               r      = mag_a % mag_b;
               res.lo = (a[31] ^ b[31]) ? -q : q;
               res.hi = a[31] ? -r : r;
            end
         end
         OP_DIVU: begin
            if (b == '0) begin
               res = {a, 32'hFFFF_FFFF};
            end else begin
               res = {a % b, a / b};
            end
         end
         default: res = '0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/md_unit.sv
// rtl/md_unit.sv - HI/LO multiply/divide unit with counter-modelled latency
module md_unit
   import md_unit_pkg::*;
#(
   parameter int MULT_LATENCY = DEF_MULT_LATENCY,
   parameter int DIV_LATENCY  = DEF_DIV_LATENCY
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] operand_a,
   input  logic [31:0] operand_b,
   input  logic        read_sel,
   output logic [31:0] read_result,
   output logic        busy
);

   localparam int MAX_LAT = (MULT_LATENCY > DIV_LATENCY) ? MULT_LATENCY : DIV_LATENCY;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);

   typedef enum logic {ST_IDLE, ST_RUN} state_e;

   state_e      state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [31:0] hi, lo;
   md_result_t  pend;
   md_op_e      op_e;
   logic        is_md, is_mt;
   logic        accept_md, accept_mt, commit;
   logic [CNT_W-1:0] lat;

   assign op_e  = md_op_e'(op);
   assign is_md = (op_e == OP_MULT) || (op_e == OP_MULTU) || (op_e == OP_DIV) || (op_e == OP_DIVU);
   assign is_mt = (op_e == OP_MTHI) || (op_e == OP_MTLO);
   assign lat   = ((op_e == OP_MULT) || (op_e == OP_MULTU)) ? CNT_W'(MULT_LATENCY)
                                                            : CNT_W'(DIV_LATENCY);

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      accept_md = 1'b0;
      accept_mt = 1'b0;
      commit    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start && is_md) begin
               accept_md = 1'b1;
               state_n   = ST_RUN;
               cnt_n     = lat;
            end else if (start && is_mt) begin
               accept_mt = 1'b1;
            end
         end
         ST_RUN: begin
            // cnt <= 1 also covers a zero latency parameter without wrapping
            if (cnt <= CNT_W'(1)) begin
               commit  = 1'b1;
               state_n = ST_IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
         hi    <= '0;
         lo    <= '0;
         pend  <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (accept_md) begin
            pend <= md_compute(op_e, operand_a, operand_b);
         end
         if (commit) begin
            hi <= pend.hi;
            lo <= pend.lo;
         end else if (accept_mt) begin
            if (op_e == OP_MTHI) begin
               hi <= operand_a;
            end else begin
               lo <= operand_a;
            end
         end
      end
   end

   assign busy        = (state == ST_RUN);
   assign read_result = (read_sel == SEL_HI) ? hi : lo;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - scoreboard bench for md_unit
module tb_md_unit;
   import md_unit_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [2:0]  op;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        read_sel;
   logic [31:0] read_result;
   logic        busy;

   md_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .op          (op),
      .operand_a   (operand_a),
      .operand_b   (operand_b),
      .read_sel    (read_sel),
      .read_result (read_result),
      .busy        (busy)
   );

   typedef struct {
      string       name;
      logic [31:0] hi;
      logic [31:0] lo;
      int          len;
   } exp_t;

   exp_t commit_q[$];
   exp_t check_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
      read_sel = SEL_LO;
      #1 lo = read_result;
      read_sel = SEL_HI;
      #1 hi = read_result;
   endtask

   // Monitor: serves snapshot checks and compares every commit (busy falling edge).
   initial begin
      exp_t        e;
      logic [31:0] hi, lo;
      logic        b;
      logic        prev_busy = 1'b0;
      int          run_len = 0;
      read_sel = SEL_LO;
      forever begin
         @(negedge clk);
         b = busy;
         if (check_q.size() > 0) begin
            e = check_q.pop_front();
            read_hilo(hi, lo);
            cmp({e.name, "_hi"}, hi, e.hi);
            cmp({e.name, "_lo"}, lo, e.lo);
         end
         if (!rst_n) begin
            prev_busy = 1'b0;
            run_len   = 0;
         end else begin
            if (b) begin
               run_len++;
            end else if (prev_busy) begin
               read_hilo(hi, lo);
               if (commit_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_commit actual hi=0x%08h lo=0x%08h required none", hi, lo);
               end else begin
                  e = commit_q.pop_front();
                  cmp({e.name, "_hi"}, hi, e.hi);
                  cmp({e.name, "_lo"}, lo, e.lo);
                  cmp({e.name, "_len"}, 32'(run_len), 32'(e.len));
               end
               run_len = 0;
            end
            prev_busy = b;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic issue(input md_op_e o, input logic [31:0] a, input logic [31:0] b);
      start     = 1'b1;
      op        = o;
      operand_a = a;
      operand_b = b;
      step();
      start     = 1'b0;
      op        = OP_NONE;
      operand_a = $urandom;
      operand_b = $urandom;
   endtask

   task automatic expect_commit(input string name, input logic [31:0] hi, input logic [31:0] lo, input int len);
      exp_t e;
      e.name = name; e.hi = hi; e.lo = lo; e.len = len;
      commit_q.push_back(e);
   endtask

   task automatic expect_now(input string name, input logic [31:0] hi, input logic [31:0] lo);
      exp_t e;
      e.name = name; e.hi = hi; e.lo = lo; e.len = 0;
      check_q.push_back(e);
   endtask

   task automatic check_busy(input string name, input logic exp);
      cmp(name, 32'(busy), 32'(exp));
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 40; i++) begin
         if (!busy) break;
         step();
      end
      check_busy({name, "_idle"}, 1'b0);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; op = OP_NONE; operand_a = '0; operand_b = '0;
      step(); step();
      check_busy("reset_busy", 1'b0);
      expect_now("reset", 32'h0, 32'h0);
      rst_n = 1'b1;
      step();

      // MULT -2 * 3
      issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
      expect_commit("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
      check_busy("mult_busy", 1'b1);
      expect_now("mult_old", 32'h0, 32'h0);
      wait_idle("mult");

      // DIVU 100 / 7, visible regs frozen until the last edge
      issue(OP_DIVU, 32'd100, 32'd7);
      expect_commit("divu", 32'd2, 32'd14, 10);
      for (int i = 0; i < 9; i++) step();
      check_busy("divu_busy9", 1'b1);
      expect_now("divu_old", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      wait_idle("divu");

      issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
      expect_commit("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
      wait_idle("div_neg");

      issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      expect_commit("div_ovf", 32'h0, 32'h8000_0000, 10);
      wait_idle("div_ovf");

      issue(OP_DIV, 32'hFFFF_FFF0, 32'h0);
      expect_commit("div_zero", 32'hFFFF_FFF0, 32'hFFFF_FFFF, 10);
      wait_idle("div_zero");

      // DIVU by zero with an MTHI issued while busy (must be dropped)
      issue(OP_DIVU, 32'h0000_1234, 32'h0);
      expect_commit("divu_zero", 32'h0000_1234, 32'hFFFF_FFFF, 10);
      step(); step();
      issue(OP_MTHI, 32'h0000_DEAD, 32'h0);
      check_busy("mthi_busy", 1'b1);
      wait_idle("divu_zero");
      step();
      expect_now("mthi_dropped", 32'h0000_1234, 32'hFFFF_FFFF);
      step();

      // Reset mid-run aborts without commit
      issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      step(); step();
      rst_n = 1'b0;
      #1;
      check_busy("abort_busy", 1'b0);
      expect_now("abort", 32'h0, 32'h0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) step();
      check_busy("abort_later", 1'b0);
      expect_now("abort_later", 32'h0, 32'h0);
      step();
      issue(OP_MTLO, 32'h0000_0055, 32'h0);
      check_busy("mtlo_busy", 1'b0);
      expect_now("mtlo", 32'h0, 32'h0000_0055);
      step();
      issue(OP_MTHI, 32'h0000_CAFE, 32'h0);
      expect_now("mthi", 32'h0000_CAFE, 32'h0000_0055);
      step();

      // Back-to-back: DIVU held on start is taken the edge after busy falls
      issue(OP_MULTU, 32'd2, 32'd3);
      expect_commit("b2b_multu", 32'h0, 32'd6, 5);
      start = 1'b1; op = OP_DIVU; operand_a = 32'd9; operand_b = 32'd4;
      for (int i = 0; i < 5; i++) step();
      check_busy("b2b_gap", 1'b0);
      expect_now("b2b_mid", 32'h0, 32'd6);
      step();
      check_busy("b2b_reissue", 1'b1);
      start = 1'b0; op = OP_NONE; operand_a = $urandom; operand_b = $urandom;
      expect_commit("b2b_divu", 32'd1, 32'd2, 10);
      wait_idle("b2b_divu");
      step(); step();

      cmp("pending_commits", 32'(commit_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 Parameter MULT_LATENCY, default 5, sets busy cycles for MULT/MULTU.
REQ-002 Parameter DIV_LATENCY, default 10, sets busy cycles for DIV/DIVU.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  issue strobe; op and operands are sampled when high.
REQ-006 op  input  3  operation code: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-007 operand_a  input  32  rs value from the register file read port 1 (dividend / multiplicand / MTxx data).
REQ-008 operand_b  input  32  rt value from the register file read port 2 (divisor / multiplier).
REQ-009 read_sel  input  1  0 selects LO, 1 selects HI (MFLO/MFHI).
REQ-010 read_result  output  32  selected HI/LO value, routed toward the register file write data.
REQ-011 busy  output  1  high while a multiply or divide is in flight.

Function
REQ-012 Accept rule: an operation is accepted at a rising edge only when start=1, busy=0 and op is not NONE; otherwise nothing changes.
REQ-013 start with busy=1 is ignored entirely, with no queueing; upstream stalls on busy.
REQ-014 MTHI/MTLO accepted at edge E write operand_a into HI/LO at E; busy stays 0.
REQ-015 MULT/MULTU/DIV/DIVU accepted at edge E0 latch the operands and computed result into pending registers; busy=1 from after E0 for exactly N cycles (N = the op's latency).
REQ-016 Commit: at edge E_N, pending HI/LO are written to visible HI/LO and busy falls at that same edge.
REQ-017 Down-counter loaded with N at E0 and decremented each edge; commit occurs when it transitions 1->0.
REQ-018 States: IDLE (busy=0) -> RUN on a mult/div accept; RUN -> IDLE on commit; there are no other states.
REQ-019 A new mult/div may be accepted at the first edge after E_N (back-to-back issue is allowed with zero bubble beyond busy).
REQ-020 Visible HI/LO remain unchanged during RUN; read_result returns the old values until the commit edge.
REQ-021 read_result is combinational from read_sel and visible HI/LO, with no latency.
REQ-022 MULT: signed 32x32 product; HI = bits 63:32, LO = bits 31:0.
REQ-023 MULTU: unsigned 32x32 product with the same split.
REQ-024 DIV: signed; LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
REQ-025 DIVU: unsigned; LO = quotient, HI = remainder.
REQ-026 Divide by zero: LO = 0xFFFFFFFF, HI = operand_a, for both DIV and DIVU.
REQ-027 Signed overflow (0x80000000 / 0xFFFFFFFF, DIV): LO = 0x80000000, HI = 0.
REQ-028 Operand changes after the accept edge have no effect on the in-flight result.

Reset
REQ-029 While rst_n=0: HI=0, LO=0, busy=0, counter=0, state IDLE, and pending registers are 0.
REQ-030 Reset asserted mid-RUN aborts the operation with no commit; HI/LO read 0 immediately (asynchronously).
REQ-031 First accept is possible at the first rising edge with rst_n=1.

Structure
REQ-032 Op encodings, read_sel encodings and default latencies are defined in the shared header md.h; no literals appear in the RTL body.
REQ-033 A single module is used with no sub-module; the result is computed at accept time and the latency is modelled by the counter.
REQ-034 Debug trace on commit and MTxx uses the team's debug header macros.

Verification
REQ-035 MULT a=0xFFFFFFFE (-2), b=3 -> busy high 5 cycles; after commit HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-036 DIVU a=100, b=7 -> busy high 10 cycles, HI/LO unchanged until E_10; then LO=14, HI=2.
REQ-037 DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-038 DIVU b=0, a=0x1234 -> LO=0xFFFFFFFF, HI=0x1234; MTHI 0xDEAD issued while busy -> ignored, HI=0x1234 after commit.
REQ-039 MULTU 0xFFFFFFFF*0xFFFFFFFF, then rst_n pulsed low at cycle 3 -> busy=0, HI=LO=0, no later commit; MTLO 0x55 next -> LO=0x55 at that edge.
REQ-040 Back-to-back: MULTU 2*3 then DIVU 9/4 accepted at the edge after busy falls -> LO=6 after 5 cycles, then LO=2, HI=1 after 10 more cycles.
